serial_adder_seq: RTL and testbench
===================================

Name: serial_adder_seq

Overview:
- Bit-serial ripple adder sequencer that sits directly downstream of the half-adder stage and extends it to multi-bit operands.
- Accepts two WIDTH-bit operands on a start strobe and processes them LSB first, one bit per cycle.
- Each bit uses a full-adder cell built from two half-adder XOR/AND pairs plus a carry register.
- Presents the registered WIDTH-bit sum and carry-out with a one-cycle done pulse. Intended to be driven from ui_in/uio_in and to drive uo_out in a tile wrapper.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  clock enable; when 0 all state holds.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the edge that accepts start.
- b  input  WIDTH  operand B; sampled on the edge that accepts start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; sum/cout valid and final.
- sum  output  WIDTH  registered result A+B modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset: on a clk edge with rst_n=0 the block returns to IDLE, whatever state it was in (including mid-RUN). All of the following are cleared: busy=0, done=0, sum=0, cout=0, carry register=0, bit counter=0, operand shift registers=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE -> RUN: on an edge with ena=1 and start=1.
  - Latch a and b into shift registers.
  - Clear the carry register and the bit counter.
  - Clear the internal partial-sum register.
- RUN, on each edge with ena=1:
  - Compute s = a_sr[0] ^ b_sr[0] ^ c.
  - Compute c_next = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0])).
  - Shift the partial-sum register right, inserting s at bit WIDTH-1.
  - Shift a_sr and b_sr right, zero-filling.
  - Update c <= c_next and increment the counter.
- RUN -> DONE: on the edge that processes bit WIDTH-1 (counter == WIDTH-1).
  - On that same edge, sum <= final partial-sum value including the bit just computed.
  - On that same edge, cout <= c_next.
- DONE -> IDLE: on the next edge with ena=1, unconditionally.
- Latency: let edge k be the edge that accepts start.
  - busy is high for exactly WIDTH cycles.
  - done is high in the cycle following edge k+WIDTH.
  - The earliest next start is accepted at edge k+WIDTH+2.
- Outputs sum/cout change only on the RUN->DONE edge or on reset. They hold through IDLE and the next RUN until the new result lands.
- start is ignored in RUN and in DONE (no queuing). a and b may change freely after the accepting edge.
- ena=0 freezes the state, counter, shift registers, carry and outputs.
  - done stays high across a stall; it clears on the first enabled edge.
  - Reset still takes effect when ena=0 (rst_n has priority over ena).
- Overflow: sum wraps modulo 2^WIDTH; the overflowed bit appears only on cout.

Test Plan:
- WIDTH=8, a=0x3C, b=0x0F, start for one cycle -> busy high for 8 cycles; done pulses exactly 9 cycles after the accepting edge with sum=0x4B, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1. The previous result holds until the new done.
- start held high continuously with a=0x12, b=0x34 -> exactly one done per 10 cycles, each with sum=0x46. Changing a/b during RUN does not alter the result.
- rst_n pulled low at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0x00, cout=0. A subsequent start a=0x01, b=0x02 yields sum=0x03.
- ena low for 3 cycles mid-RUN and again while done=1 -> the result is unchanged (0x3C+0x0F=0x4B). done stays high for the 3 stalled cycles and clears on the next enabled edge.
- Random sweep of 1000 operand pairs -> {cout,sum} == a+b in every case; busy and done are never high simultaneously.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands LSB first, one bit per
// enabled clock, using a two-half-adder full-adder cell and a carry register.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sr_reg, a_sr_next;
    logic [WIDTH-1:0]   b_sr_reg, b_sr_next;
    logic [WIDTH-1:0]   psum_reg, psum_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               cout_reg, cout_next;
    logic               carry_reg, carry_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    // Full adder as two cascaded half adders on the current LSBs.
    logic ha1_sum, ha1_carry, ha2_sum, ha2_carry, fa_carry;

    assign ha1_sum   = a_sr_reg[0] ^ b_sr_reg[0];
    assign ha1_carry = a_sr_reg[0] & b_sr_reg[0];
    assign ha2_sum   = ha1_sum ^ carry_reg;
    assign ha2_carry = ha1_sum & carry_reg;
    assign fa_carry  = ha1_carry | ha2_carry;

    always_comb begin
        state_next = state_reg;
        a_sr_next  = a_sr_reg;
        b_sr_next  = b_sr_reg;
        psum_next  = psum_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    a_sr_next  = a;
                    b_sr_next  = b;
                    psum_next  = '0;
                    carry_next = 1'b0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                psum_next  = {ha2_sum, psum_reg[WIDTH-1:1]};
                a_sr_next  = {1'b0, a_sr_reg[WIDTH-1:1]};
                b_sr_next  = {1'b0, b_sr_reg[WIDTH-1:1]};
                carry_next = fa_carry;
                cnt_next   = cnt_reg + CNT_W'(1);
                // The last bit lands in the visible result on the same edge.
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = DONE;
                    sum_next   = {ha2_sum, psum_reg[WIDTH-1:1]};
                    cout_next  = fa_carry;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset outranks the clock enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (ena) begin
            state_reg <= state_next;
            a_sr_reg  <= a_sr_next;
            b_sr_reg  <= b_sr_next;
            psum_reg  <= psum_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: vector table, hand-written timing
// corner cases and a random sweep against plain integer addition.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests;
    int fails;
    logic [W:0] prev_res;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W:0]   vexp;
    } vec_t;

    vec_t vecs [8];

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition from IDLE; leaves the DUT back in IDLE.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W:0] exp, input bit scramble);
        int   edges;
        int   nbusy;
        logic both;
        logic held_ok;
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        nbusy = 0;
        both = 1'b0;
        held_ok = 1'b1;
        while (!done && edges < 4 * W) begin
            if (busy) nbusy++;
            if (busy && done) both = 1'b1;
            if ({cout, sum} !== prev_res) held_ok = 1'b0;
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            edges++;
        end
        check("latency", edges, W);
        check("busy_cycles", nbusy, W);
        check("result", {cout, sum}, exp);
        check("busy_done_exclusive", both, 0);
        check("prev_result_hold", held_ok, 1);
        $display("[TB] add a=0x%02h b=0x%02h -> cout=%0d sum=0x%02h", x, y, cout, sum);
        prev_res = exp;
        tick();
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        prev_res = '0;
        rst_n = 1'b0;
        ena = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;

        vecs[0] = '{8'h3C, 8'h0F, 9'h04B};
        vecs[1] = '{8'hFF, 8'h01, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{8'h12, 8'h34, 9'h046};
        vecs[4] = '{8'h00, 8'h00, 9'h000};
        vecs[5] = '{8'h80, 8'h80, 9'h100};
        vecs[6] = '{8'hAA, 8'h55, 9'h0FF};
        vecs[7] = '{8'h01, 8'h02, 9'h003};

        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", {cout, sum}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            do_add(vecs[i].va, vecs[i].vb, vecs[i].vexp, 1'b0);

        // Operands scrambled while running must not disturb the result.
        do_add(8'h3C, 8'h0F, 9'h04B, 1'b1);

        // start held high: one result every WIDTH+2 cycles.
        begin
            int ndone;
            int first;
            int last;
            logic spacing_ok;
            ndone = 0;
            first = -1;
            last = -1;
            spacing_ok = 1'b1;
            a = 8'h12;
            b = 8'h34;
            start = 1'b1;
            for (int e = 1; e <= 30; e++) begin
                tick();
                if (done) begin
                    if (last >= 0 && e - last != W + 2) spacing_ok = 1'b0;
                    if (first < 0) first = e;
                    last = e;
                    ndone++;
                    check("held_start_result", {cout, sum}, 9'h046);
                end
            end
            start = 1'b0;
            check("held_start_count", ndone, 3);
            check("held_start_first", first, W + 1);
            check("held_start_spacing", spacing_ok, 1);
            $display("[TB] held start a=0x12 b=0x34 -> %0d results", ndone);
            prev_res = 9'h046;
        end

        // Reset in the fourth RUN cycle clears everything.
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_result", {cout, sum}, 0);
        $display("[TB] reset mid-run");
        prev_res = '0;
        do_add(8'h01, 8'h02, 9'h003, 1'b0);

        // ena stalls mid-run and while done is high.
        begin
            logic stall_busy_ok;
            int   done_stalled;
            stall_busy_ok = 1'b1;
            done_stalled = 0;
            a = 8'h3C;
            b = 8'h0F;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
            ena = 1'b0;
            repeat (3) begin
                tick();
                if (!busy || done) stall_busy_ok = 1'b0;
            end
            ena = 1'b1;
            check("stall_run_frozen", stall_busy_ok, 1);
            repeat (4) tick();
            check("stall_not_early", done, 0);
            tick();
            check("stall_done", done, 1);
            check("stall_result", {cout, sum}, 9'h04B);
            ena = 1'b0;
            repeat (3) begin
                tick();
                if (done) done_stalled++;
            end
            check("stall_done_held", done_stalled, 3);
            ena = 1'b1;
            tick();
            check("stall_done_clear", done, 0);
            check("stall_result_kept", {cout, sum}, 9'h04B);
            $display("[TB] stalled add a=0x3C b=0x0F -> cout=%0d sum=0x%02h", cout, sum);
            ena = 1'b0;
            rst_n = 1'b0;
            tick();
            check("reset_over_ena", {cout, sum}, 0);
            rst_n = 1'b1;
            ena = 1'b1;
            prev_res = '0;
            tick();
        end

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic [W:0]   ref_sum;
            x = W'($urandom);
            y = W'($urandom);
            ref_sum = (W+1)'(int'(x) + int'(y));
            do_add(x, y, ref_sum, i[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
